// File: rtl/forthsuper_pkg.sv
// Shared definitions for the stack-machine blocks: op encodings, controller
// states and small stack-geometry helpers.
package forthsuper_pkg;

    typedef enum logic [1:0] {
        SS_LOAD = 2'd0,
        SS_PUSH = 2'd1,
        SS_POP  = 2'd2,
        SS_PICK = 2'd3
    } sop_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_PICK_RD = 2'd2
    } ss_state_e;

    localparam int SS_DEF_DEPTH = 64;
    localparam int SS_DEF_DSZ   = 32;

    // Pointer width for a RAM of the given depth.
    function automatic int ss_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ss_ram.sv
// Single-port stack storage: synchronous write, synchronous read with one
// cycle of latency.
module ss_ram #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic           re,
    input  logic [AW-1:0]  addr,
    input  logic [DSZ-1:0] wdata,
    output logic [DSZ-1:0] rdata
);

    logic [DSZ-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/ss_stk.sv
// Data stack with registered TOS and second element over a RAM spill area.
// Define SS_GUARD_EN to reject overflow, underflow and out-of-range PICK.
module ss_stk
    import forthsuper_pkg::*;
#(
    parameter int DEPTH = SS_DEF_DEPTH,
    parameter int DSZ   = SS_DEF_DSZ,
    localparam int SSZ  = ss_ptr_w(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  sop_e           op,
    input  logic [DSZ-1:0] vi,
    output logic           rdy,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] s0,
    output logic [SSZ-1:0] sp,
    output logic [SSZ-1:0] sp_1,
    output logic [SSZ:0]   cnt,
    output logic           full,
    output logic           empty,
    output logic           pick_vld,
    output logic           err
);

    ss_state_e      state, state_nxt;
    logic           acc, reject, exec;
    logic [SSZ:0]   pick_raw, pick_n, pick_q;
    logic           ram_we, ram_re;
    logic [SSZ-1:0] ram_addr;
    logic [DSZ-1:0] ram_rdata;

    assign acc      = en && (state == ST_IDLE);
    assign pick_raw = vi[SSZ:0];
    assign pick_n   = (pick_raw > (SSZ+1)'(DEPTH)) ? pick_raw - (SSZ+1)'(DEPTH + 1) : pick_raw;
    assign full     = (cnt == (SSZ+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign sp_1     = sp - SSZ'(1);

`ifdef SS_GUARD_EN
    assign reject = acc && (((op == SS_PUSH) && full) ||
                            ((op == SS_POP)  && empty) ||
                            ((op == SS_PICK) && (pick_raw > cnt)));
`else
    assign reject = 1'b0;
`endif
    assign exec = acc && !reject;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (exec && (op == SS_POP))
                    state_nxt = ST_REFILL;
                else if (exec && (op == SS_PICK))
                    state_nxt = ST_PICK_RD;
            end
            ST_REFILL:  state_nxt = ST_IDLE;
            ST_PICK_RD: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // RAM is only touched from IDLE, so a read and a write never share a cycle.
    always_comb begin
        rdy      = (state == ST_IDLE);
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = sp;
        if (exec) begin
            case (op)
                SS_PUSH: ram_we = 1'b1;
                SS_POP: begin
                    ram_re   = 1'b1;
                    ram_addr = sp - SSZ'(2);
                end
                SS_PICK: begin
                    ram_re   = 1'b1;
                    ram_addr = sp - pick_n[SSZ-1:0];
                end
                default: ;
            endcase
        end
    end

    // s0 always mirrors ram[sp-1]; POP refills it from the slot below.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos      <= '1;
            s0       <= '0;
            sp       <= '0;
            cnt      <= '0;
            pick_q   <= '0;
            pick_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            pick_vld <= 1'b0;
            err      <= reject;
            case (state)
                ST_IDLE: begin
                    if (exec) begin
                        case (op)
                            SS_LOAD: tos <= vi;
                            SS_PUSH: begin
                                s0  <= tos;
                                tos <= vi;
                                sp  <= sp + SSZ'(1);
                                if (!full)
                                    cnt <= cnt + (SSZ+1)'(1);
                            end
                            SS_POP: begin
                                tos <= s0;
                                sp  <= sp - SSZ'(1);
                                if (!empty)
                                    cnt <= cnt - (SSZ+1)'(1);
                            end
                            SS_PICK: pick_q <= pick_n;
                            default: ;
                        endcase
                    end
                end
                ST_REFILL:
                    s0 <= empty ? '0 : ram_rdata;
                ST_PICK_RD: begin
                    if (pick_q == '0)
                        tos <= tos;
                    else if (pick_q == (SSZ+1)'(1))
                        tos <= s0;
                    else
                        tos <= ram_rdata;
                    pick_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    ss_ram #(
        .DEPTH (DEPTH),
        .DSZ   (DSZ),
        .AW    (SSZ)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (tos),
        .rdata (ram_rdata)
    );

endmodule
